// File: rtl/lbist_session_ctrl.sv
// lbist_session_ctrl
//   Sequences one logic-BIST session on a core: holds test mode for a setup
//   window, waits in RUN for the core's test-complete flag (or a timeout),
//   then reports the verdict and keeps pass/fail session tallies.
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i, mode_i         session request / normal_test value for the session
//   abort_i, clear_i        cancel the session / zero the tallies
//   func_clock_en_i         functional clock enable, used when no session runs
//   go_nogo_i, test_over_i  core verdict (1 = pass) and core completion flag
//   test_mode_o, normal_test_o, clock_en_o   controls into the core
//   busy_o, done_o, pass_o, timeout_o        session status
//   pass_cnt_o, fail_cnt_o                   saturating session tallies
module lbist_session_ctrl #(
  parameter int SETUP_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic                 abort_i,
  input  logic                 clear_i,
  input  logic                 func_clock_en_i,
  input  logic                 go_nogo_i,
  input  logic                 test_over_i,
  output logic                 test_mode_o,
  output logic                 normal_test_o,
  output logic                 clock_en_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 timeout_o,
  output logic [CNT_WIDTH-1:0] pass_cnt_o,
  output logic [CNT_WIDTH-1:0] fail_cnt_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Terminal counts: the counters start at 0 on entry to their state.
  localparam logic [7:0]  SETUP_LAST = 8'(SETUP_CYCLES - 1);
  localparam logic [15:0] RUN_LAST   = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]           state_q, state_d;
  logic [7:0]           setup_cnt_q, setup_cnt_d;
  logic [15:0]          run_cnt_q, run_cnt_d;
  logic                 mode_q, mode_d;
  logic                 over_q;
  logic                 pass_q, pass_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_WIDTH-1:0] fail_cnt_q, fail_cnt_d;
  logic                 test_mode_q, test_mode_d;
  logic                 normal_q, normal_d;
  logic                 done_q, done_d;
  logic                 pass_inc, fail_inc;
  logic                 over_rise;

  // Completion is an edge, so a flag left high from a previous test
  // cannot end the new session immediately.
  assign over_rise = test_over_i & ~over_q;

  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    run_cnt_d   = run_cnt_q;
    mode_d      = mode_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    pass_inc    = 1'b0;
    fail_inc    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d     = S_SETUP;
          setup_cnt_d = '0;
          mode_d      = mode_i;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
        end
      end
      S_SETUP: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (setup_cnt_q == SETUP_LAST) begin
          state_d   = S_RUN;
          run_cnt_d = '0;
        end else begin
          setup_cnt_d = setup_cnt_q + 8'd1;
        end
      end
      default: begin // S_RUN; abort beats completion beats timeout
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (over_rise) begin
          state_d  = S_DONE;
          pass_d   = go_nogo_i;
          pass_inc = go_nogo_i;
          fail_inc = ~go_nogo_i;
        end else if (run_cnt_q == RUN_LAST) begin
          state_d   = S_DONE;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
          fail_inc  = 1'b1;
        end else begin
          run_cnt_d = run_cnt_q + 16'd1;
        end
      end
    endcase
  end

  // Tallies saturate at all-ones; clear wins over a same-cycle increment.
  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (clear_i) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
    end else begin
      if (pass_inc && !(&pass_cnt_q)) pass_cnt_d = pass_cnt_q + 1'b1;
      if (fail_inc && !(&fail_cnt_q)) fail_cnt_d = fail_cnt_q + 1'b1;
    end
  end

  // Output registers are loaded from the next state so they line up with it.
  always_comb begin
    test_mode_d = (state_d == S_SETUP) || (state_d == S_RUN);
    normal_d    = test_mode_d & mode_d;
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      setup_cnt_q <= '0;
      run_cnt_q   <= '0;
      mode_q      <= 1'b0;
      over_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      test_mode_q <= 1'b0;
      normal_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      run_cnt_q   <= run_cnt_d;
      mode_q      <= mode_d;
      over_q      <= test_over_i;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      test_mode_q <= test_mode_d;
      normal_q    <= normal_d;
      done_q      <= done_d;
    end
  end

  assign test_mode_o   = test_mode_q;
  assign normal_test_o = normal_q;
  assign busy_o        = test_mode_q;
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign timeout_o     = timeout_q;
  assign pass_cnt_o    = pass_cnt_q;
  assign fail_cnt_o    = fail_cnt_q;
  // Core clock is forced on for the whole session, functional otherwise.
  assign clock_en_o    = test_mode_q | func_clock_en_i;

endmodule

// File: tb/tb_lbist_session_ctrl.sv
module tb_lbist_session_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic start = 1'b0, mode = 1'b0, abort = 1'b0, clr = 1'b0;
  logic fce = 1'b0, gng = 1'b0, over = 1'b0;
  logic a_tm, a_nt, a_ce, a_busy, a_done, a_pass, a_to;
  logic [7:0] a_pc, a_fc;
  logic b_tm, b_nt, b_ce, b_busy, b_done, b_pass, b_to;
  logic [1:0] b_pc, b_fc;
  int nerr = 0, nchk = 0;

  always #5 clk = ~clk;

  // dut_a: defaults; dut_b: short timeout, 2-bit tallies. Inputs are shared.
  lbist_session_ctrl dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .abort_i(abort),
    .clear_i(clr), .func_clock_en_i(fce), .go_nogo_i(gng), .test_over_i(over),
    .test_mode_o(a_tm), .normal_test_o(a_nt), .clock_en_o(a_ce), .busy_o(a_busy),
    .done_o(a_done), .pass_o(a_pass), .timeout_o(a_to),
    .pass_cnt_o(a_pc), .fail_cnt_o(a_fc));

  lbist_session_ctrl #(.SETUP_CYCLES(4), .TIMEOUT_CYCLES(10), .CNT_WIDTH(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .abort_i(abort),
    .clear_i(clr), .func_clock_en_i(fce), .go_nogo_i(gng), .test_over_i(over),
    .test_mode_o(b_tm), .normal_test_o(b_nt), .clock_en_o(b_ce), .busy_o(b_busy),
    .done_o(b_done), .pass_o(b_pass), .timeout_o(b_to),
    .pass_cnt_o(b_pc), .fail_cnt_o(b_fc));

  typedef struct {
    logic tm, nt, busy, done, pass, to, ce;
    int   pc, fc;
  } exp_t;

  typedef struct {
    int   n;
    logic st, md, ab, cl, f, gn, ov;
    exp_t e;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[$];

  function automatic exp_t E(logic tm, nt, busy, done, pass, to, int pc, int fc);
    exp_t e;
    e.tm = tm; e.nt = nt; e.busy = busy; e.done = done; e.pass = pass; e.to = to;
    e.ce = 1'b0; e.pc = pc; e.fc = fc;
    return e;
  endfunction

  function automatic vec_t V(int n, logic st, md, ab, cl, f, gn, ov, exp_t e);
    vec_t v;
    v.n = n; v.st = st; v.md = md; v.ab = ab; v.cl = cl; v.f = f; v.gn = gn; v.ov = ov;
    v.e = e;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(string nm, int sel, logic st, md, ab, cl, f, gn, ov, exp_t e);
    exp_t x;
    logic [6:0] fl;
    logic [31:0] pc, fc;
    start = st; mode = md; abort = ab; clr = cl; fce = f; gng = gn; over = ov;
    e.ce = e.busy | f;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    if (sel == 0) begin
      fl = {a_tm, a_nt, a_busy, a_done, a_pass, a_to, a_ce};
      pc = {24'd0, a_pc}; fc = {24'd0, a_fc};
    end else begin
      fl = {b_tm, b_nt, b_busy, b_done, b_pass, b_to, b_ce};
      pc = {30'd0, b_pc}; fc = {30'd0, b_fc};
    end
    chk({nm, " tm/nt/busy/done/pass/to/ce"}, {25'd0, fl},
        {25'd0, x.tm, x.nt, x.busy, x.done, x.pass, x.to, x.ce});
    chk({nm, " pass_cnt"}, pc, x.pc);
    chk({nm, " fail_cnt"}, fc, x.fc);
  endtask

  task automatic do_reset();
    start = 0; mode = 0; abort = 0; clr = 0; fce = 0; gng = 0; over = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state, checked before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst a flags", {26'd0, a_tm, a_nt, a_busy, a_done, a_pass, a_to}, 32'd0);
    chk("rst a cnts", {16'd0, a_pc, a_fc}, 32'd0);
    chk("rst b flags", {26'd0, b_tm, b_nt, b_busy, b_done, b_pass, b_to}, 32'd0);
    chk("rst ce=0", {31'd0, a_ce}, 32'd0);
    fce = 1'b1;
    #1;
    chk("rst ce=1", {31'd0, a_ce}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fce = 1'b0;

    // ---- table: pass path, fail path, abort, abort in DONE (dut_a)
    //          n  st md ab cl f  gn ov   tm nt bs dn ps to pc fc
    tbl.push_back(V(1, 1, 1, 0, 0, 0, 0, 0, E(1, 1, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(V(5, 0, 1, 0, 0, 0, 0, 0, E(1, 1, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(V(2, 1, 0, 0, 0, 0, 0, 0, E(1, 1, 1, 0, 0, 0, 0, 0))); // start ignored
    tbl.push_back(V(12, 0, 0, 0, 0, 0, 0, 0, E(1, 1, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(V(1, 0, 0, 0, 0, 1, 1, 1, E(0, 0, 0, 1, 1, 0, 1, 0))); // cycle 20 rise
    tbl.push_back(V(2, 0, 0, 0, 0, 0, 0, 0, E(0, 0, 0, 1, 1, 0, 1, 0)));
    tbl.push_back(V(1, 1, 0, 0, 0, 0, 0, 0, E(1, 0, 1, 0, 0, 0, 1, 0))); // restart from DONE
    tbl.push_back(V(19, 0, 0, 0, 0, 0, 0, 0, E(1, 0, 1, 0, 0, 0, 1, 0)));
    tbl.push_back(V(1, 0, 0, 0, 0, 1, 0, 1, E(0, 0, 0, 1, 0, 0, 1, 1))); // fail verdict
    tbl.push_back(V(1, 0, 0, 0, 0, 1, 0, 1, E(0, 0, 0, 1, 0, 0, 1, 1)));
    tbl.push_back(V(1, 1, 1, 0, 0, 0, 0, 0, E(1, 1, 1, 0, 0, 0, 1, 1)));
    tbl.push_back(V(5, 0, 1, 0, 0, 0, 0, 0, E(1, 1, 1, 0, 0, 0, 1, 1)));
    tbl.push_back(V(1, 0, 1, 1, 0, 1, 1, 1, E(0, 0, 0, 0, 0, 0, 1, 1))); // abort + rise
    tbl.push_back(V(2, 0, 0, 1, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 1, 1))); // abort in IDLE
    tbl.push_back(V(1, 1, 0, 0, 0, 0, 0, 0, E(1, 0, 1, 0, 0, 0, 1, 1)));
    tbl.push_back(V(19, 0, 0, 0, 0, 0, 0, 0, E(1, 0, 1, 0, 0, 0, 1, 1)));
    tbl.push_back(V(1, 0, 0, 0, 0, 0, 1, 1, E(0, 0, 0, 1, 1, 0, 2, 1)));
    tbl.push_back(V(1, 0, 0, 1, 0, 0, 0, 0, E(0, 0, 0, 1, 1, 0, 2, 1))); // abort in DONE
    foreach (tbl[i])
      for (int k = 0; k < tbl[i].n; k++)
        step($sformatf("vec%0d.%0d", i, k), 0, tbl[i].st, tbl[i].md, tbl[i].ab,
             tbl[i].cl, tbl[i].f, tbl[i].gn, tbl[i].ov, tbl[i].e);

    // ---- rise in the last SETUP cycle is ignored; RUN starts at cycle 5
    step("sA start", 0, 1, 1, 0, 0, 0, 0, 0, E(1, 1, 1, 0, 0, 0, 2, 1));
    for (int k = 1; k <= 3; k++) step("sA setup", 0, 0, 1, 0, 0, 0, 0, 0, E(1, 1, 1, 0, 0, 0, 2, 1));
    step("sA c4 rise", 0, 0, 1, 0, 0, 0, 1, 1, E(1, 1, 1, 0, 0, 0, 2, 1));
    step("sA c5 fall", 0, 0, 1, 0, 0, 0, 1, 0, E(1, 1, 1, 0, 0, 0, 2, 1));
    step("sA c6 rise", 0, 0, 1, 0, 0, 0, 0, 1, E(0, 0, 0, 1, 0, 0, 2, 2));
    // ---- rise in the very first RUN cycle counts
    step("sB start", 0, 1, 1, 0, 0, 0, 0, 0, E(1, 1, 1, 0, 0, 0, 2, 2));
    for (int k = 1; k <= 4; k++) step("sB setup", 0, 0, 1, 0, 0, 0, 0, 0, E(1, 1, 1, 0, 0, 0, 2, 2));
    step("sB c5 rise", 0, 0, 1, 0, 0, 0, 1, 1, E(0, 0, 0, 1, 1, 0, 3, 2));

    // ---- timeout with test_over held high (dut_b, TIMEOUT_CYCLES=10)
    do_reset();
    step("to start", 1, 1, 0, 0, 0, 0, 0, 1, E(1, 0, 1, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 13; k++) step("to wait", 1, 0, 0, 0, 0, 0, 0, 1, E(1, 0, 1, 0, 0, 0, 0, 0));
    step("to expire", 1, 0, 0, 0, 0, 1, 0, 1, E(0, 0, 0, 1, 0, 1, 0, 1));
    step("to hold", 1, 0, 0, 0, 0, 0, 0, 1, E(0, 0, 0, 1, 0, 1, 0, 1));
    // ---- completion in the timeout cycle wins
    step("prec start", 1, 1, 0, 0, 0, 0, 0, 0, E(1, 0, 1, 0, 0, 0, 0, 1));
    for (int k = 1; k <= 13; k++) step("prec wait", 1, 0, 0, 0, 0, 0, 0, 0, E(1, 0, 1, 0, 0, 0, 0, 1));
    step("prec rise", 1, 0, 0, 0, 0, 0, 1, 1, E(0, 0, 0, 1, 1, 0, 1, 1));

    // ---- saturation (2-bit tallies) and clear (dut_b)
    do_reset();
    for (int s = 1; s <= 5; s++) begin
      int prev, now;
      prev = (s - 1 > 3) ? 3 : s - 1;
      now  = (s > 3) ? 3 : s;
      step($sformatf("sat%0d start", s), 1, 1, 1, 0, 0, 0, 0, 0, E(1, 1, 1, 0, 0, 0, prev, 0));
      for (int k = 1; k <= 5; k++)
        step($sformatf("sat%0d run", s), 1, 0, 1, 0, 0, 0, 0, 0, E(1, 1, 1, 0, 0, 0, prev, 0));
      step($sformatf("sat%0d done", s), 1, 0, 1, 0, 0, 0, 1, 1, E(0, 0, 0, 1, 1, 0, now, 0));
    end
    step("clr done", 1, 0, 0, 0, 1, 0, 0, 0, E(0, 0, 0, 1, 1, 0, 0, 0));
    step("clrinc start", 1, 1, 1, 0, 0, 0, 0, 0, E(1, 1, 1, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 5; k++) step("clrinc run", 1, 0, 1, 0, 0, 0, 0, 0, E(1, 1, 1, 0, 0, 0, 0, 0));
    step("clrinc done", 1, 0, 1, 0, 1, 0, 1, 1, E(0, 0, 0, 1, 1, 0, 0, 0));
    step("p1 start", 1, 1, 1, 0, 0, 0, 0, 0, E(1, 1, 1, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 5; k++) step("p1 run", 1, 0, 1, 0, 0, 0, 0, 0, E(1, 1, 1, 0, 0, 0, 0, 0));
    step("p1 done", 1, 0, 1, 0, 0, 0, 1, 1, E(0, 0, 0, 1, 1, 0, 1, 0));

    // ---- async reset mid-RUN, between edges
    step("ar start", 1, 1, 1, 0, 0, 0, 0, 0, E(1, 1, 1, 0, 0, 0, 1, 0));
    for (int k = 1; k <= 6; k++) step("ar run", 1, 0, 1, 0, 0, 0, 0, 0, E(1, 1, 1, 0, 0, 0, 1, 0));
    #3 rst = 1'b1;
    fce = 1'b1;
    #1;
    chk("ar b flags", {26'd0, b_tm, b_nt, b_busy, b_done, b_pass, b_to}, 32'd0);
    chk("ar b cnts", {28'd0, b_pc, b_fc}, 32'd0);
    chk("ar b ce=1", {31'd0, b_ce}, 32'd1);
    chk("ar a busy", {31'd0, a_busy}, 32'd0);
    fce = 1'b0;
    #1;
    chk("ar b ce=0", {31'd0, b_ce}, 32'd0);
    #1 rst = 1'b0;
    for (int k = 0; k < 2; k++) step("ar after", 1, 0, 0, 0, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/lbist_session_ctrl.md
LBIST_SESSION_CTRL -- requirements
Module: lbist_session_ctrl

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 4, meaning the number of cycles test_mode_o is held before RUN is entered (range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning the maximum number of RUN cycles spent waiting for test_over_i (range 1..65535, 16-bit counter).
REQ-003 SHALL have parameter CNT_WIDTH, default 8, meaning the width of the pass and fail counters.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start_i, input, 1 bit: session request, sampled in IDLE or DONE only.
REQ-007 SHALL have port mode_i, input, 1 bit: value driven on normal_test_o for the session, latched at start.
REQ-008 SHALL have port abort_i, input, 1 bit: cancels the session.
REQ-009 SHALL have port clear_i, input, 1 bit: clears the counters.
REQ-010 SHALL have port func_clock_en_i, input, 1 bit: functional clock enable, passed through when no session is active.
REQ-011 SHALL have port go_nogo_i, input, 1 bit: core signature verdict, 1 = pass.
REQ-012 SHALL have port test_over_i, input, 1 bit: core test-complete flag.
REQ-013 SHALL have port test_mode_o, output, 1 bit: driven to the core test_mode_i.
REQ-014 SHALL have port normal_test_o, output, 1 bit: driven to the core normal_test_i.
REQ-015 SHALL have port clock_en_o, output, 1 bit: driven to the core clock_en_i.
REQ-016 SHALL have port busy_o, output, 1 bit: high in SETUP and RUN.
REQ-017 SHALL have port done_o, output, 1 bit: high in DONE.
REQ-018 SHALL have port pass_o, output, 1 bit: verdict of the last session, valid while done_o is high.
REQ-019 SHALL have port timeout_o, output, 1 bit: high when the last session ended by timeout.
REQ-020 SHALL have ports pass_cnt_o and fail_cnt_o, output, CNT_WIDTH bits each: session tallies.

Function
REQ-021 SHALL implement the states IDLE, SETUP, RUN and DONE; all outputs except clock_en_o SHALL be registered.
REQ-022 SHALL leave IDLE or DONE on start_i=1 and enter SETUP on the next edge; in the same edge it latches mode_i and clears pass_o and timeout_o.
REQ-023 SHALL ignore start_i in SETUP and RUN.
REQ-024 SHALL stay in SETUP for exactly SETUP_CYCLES cycles, then enter RUN.
REQ-025 SHALL drive test_mode_o=1 in SETUP and RUN and 0 otherwise; normal_test_o SHALL equal the latched mode in SETUP and RUN and be 0 otherwise.
REQ-026 SHALL drive clock_en_o=1 combinationally in SETUP and RUN; otherwise clock_en_o SHALL equal func_clock_en_i.
REQ-027 SHALL register test_over_i each cycle; completion is a rising edge seen in RUN (test_over_i=1 with the previous sample 0), so a flag already high on RUN entry does not count.
REQ-028 On completion, SHALL enter DONE, set pass_o=go_nogo_i sampled in that same cycle, and increment pass_cnt_o or fail_cnt_o accordingly.
REQ-029 SHALL count RUN cycles; if the count reaches TIMEOUT_CYCLES without completion, it SHALL enter DONE with pass_o=0 and timeout_o=1, and increment fail_cnt_o.
REQ-030 If completion and timeout occur in the same cycle, completion SHALL take precedence.
REQ-031 Counters SHALL saturate at all-ones and never wrap.
REQ-032 abort_i=1 in SETUP or RUN SHALL return to IDLE on the next edge with no counter change and with pass_o and timeout_o unchanged; abort_i SHALL have priority over completion and timeout, and SHALL have no effect in IDLE or DONE.
REQ-033 clear_i=1 SHALL zero both counters on the next edge; if clear_i and an increment coincide, the clear SHALL win.
REQ-034 DONE SHALL persist until start_i, which begins a new session directly.

Reset
REQ-035 rst_i=1 SHALL immediately force state IDLE and set test_mode_o, normal_test_o, busy_o, done_o, pass_o and timeout_o to 0; it SHALL zero the counters, the latched mode and the test_over_i sample; clock_en_o SHALL then follow func_clock_en_i.
REQ-036 Reset asserted mid-session SHALL abandon the session without incrementing any counter.

Verification
REQ-037 SHALL cover the pass path: SETUP_CYCLES=4; start_i pulse at cycle 0, mode_i=1 -> test_mode_o=1 and normal_test_o=1 from cycle 1, RUN from cycle 5; test_over_i rises at cycle 20 with go_nogo_i=1 -> done_o=1 and pass_o=1 at cycle 21, pass_cnt_o=1.
REQ-038 SHALL cover the fail path: as REQ-037 but with go_nogo_i=0 -> pass_o=0, fail_cnt_o=1, timeout_o=0.
REQ-039 SHALL cover timeout: TIMEOUT_CYCLES=10 and test_over_i held 1 throughout -> no completion detected, timeout_o=1 after 10 RUN cycles, fail_cnt_o incremented.
REQ-040 SHALL cover abort: abort_i in RUN coinciding with a test_over_i rising edge -> IDLE next cycle, test_mode_o=0, counters unchanged.
REQ-041 SHALL cover saturation and clear: CNT_WIDTH=2 with 5 passing sessions -> pass_cnt_o=3; clear_i in DONE -> pass_cnt_o=0 and fail_cnt_o=0 on the next edge.
REQ-042 SHALL cover async reset: rst_i asserted mid-RUN, between clock edges -> test_mode_o=0 and busy_o=0 immediately, counters=0, clock_en_o=func_clock_en_i.
